// File: rtl/multicycle_core.sv
// Multicycle 16-bit-ISA core: FETCH/DECODE/EXEC/MEM/WB state machine sharing one
// req/ready memory port, with an internal 8-entry register file and ALU.
module multicycle_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instr_count,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_J    = 4'd5;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} stateT;

  stateT             state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regA;
  logic [DATA_W-1:0] regB;
  logic [DATA_W-1:0] aluOut;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] regFile [8];

  logic [3:0]        op;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [2:0]        rd;
  logic [2:0]        funct;
  logic [2:0]        wbDest;
  logic [DATA_W-1:0] immData;
  logic [ADDR_W-1:0] immPc;
  logic [ADDR_W-1:0] jumpTarget;
  logic              illegal;
  logic              isMem;

  assign op         = ir[15:12];
  assign rs         = ir[11:9];
  assign rt         = ir[8:6];
  assign rd         = ir[5:3];
  assign funct      = ir[2:0];
  assign immData    = {{(DATA_W-6){ir[5]}}, ir[5:0]};
  assign immPc      = {{(ADDR_W-6){ir[5]}}, ir[5:0]};
  assign jumpTarget = {pc[ADDR_W-1:12], ir[11:0]};
  assign illegal    = (op > OP_J) || ((op == OP_R) && (funct > 3'd4));
  assign wbDest     = (op == OP_R) ? rd : rt;
  assign isMem      = (op == OP_LW) || (op == OP_SW);

  // Memory port is a pure decode of the state, forced idle while reset is high
  // so an abandoned access never lingers into the reset cycle.
  assign mem_req   = !reset && ((state == FETCH) || (state == MEM));
  assign mem_we    = !reset && (state == MEM) && (op == OP_SW);
  assign mem_addr  = reset ? '0 : ((state == MEM) ? aluOut[ADDR_W-1:0] : pc);
  assign mem_wdata = (!reset && (state == MEM)) ? regB : '0;
  assign dbg_data  = regFile[dbg_sel];

  function automatic logic [DATA_W-1:0] aluFn(input logic [3:0]        opc,
                                              input logic [2:0]        fn,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] imm);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa    = a;
    sb    = b;
    aluFn = a + imm;
    if (opc == OP_R) begin
      case (fn)
        3'd0:    aluFn = a + b;
        3'd1:    aluFn = a - b;
        3'd2:    aluFn = a & b;
        3'd3:    aluFn = a | b;
        3'd4:    aluFn = {{(DATA_W-1){1'b0}}, (sa < sb)};
        default: aluFn = '0;
      endcase
    end
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      regA        <= '0;
      regB        <= '0;
      aluOut      <= '0;
      mdr         <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
      for (int i = 0; i < 8; i++) regFile[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata[15:0];
            pc    <= pc + ADDR_W'(1);
            state <= DECODE;
          end
        end
        DECODE: begin
          regA <= regFile[rs];
          regB <= regFile[rt];
          if (illegal) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (op == OP_J) begin
            pc          <= jumpTarget;
            instr_count <= instr_count + 32'd1;
            state       <= FETCH;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          aluOut <= aluFn(op, funct, regA, regB, immData);
          // pc already points past the branch, so the offset is added directly.
          if (op == OP_BEQ) begin
            if (regA == regB) pc <= pc + immPc;
            instr_count <= instr_count + 32'd1;
            state       <= FETCH;
          end else if (isMem) begin
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              instr_count <= instr_count + 32'd1;
              state       <= FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= WB;
            end
          end
        end
        WB: begin
          if (wbDest != 3'd0) regFile[wbDest] <= (op == OP_LW) ? mdr : aluOut;
          instr_count <= instr_count + 32'd1;
          state       <= FETCH;
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          halted <= 1'b1;
          state  <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: a 16-bit core driven by a retirement scoreboard and a
// 32-bit core for wide arithmetic and reset-during-access behaviour.
module tb_multicycle_core;

  logic        clock;
  logic        reset16, reset32;
  logic        req16, we16, ready16, halted16;
  logic [15:0] addr16, wdata16, rdata16, pc16, dbg16;
  logic [31:0] cnt16;
  logic [2:0]  dbgSel16;
  logic        req32, we32, ready32, halted32;
  logic [15:0] addr32, pc32;
  logic [31:0] wdata32, rdata32, dbg32, cnt32;
  logic [2:0]  dbgSel32;

  logic [15:0] mem16 [65536];
  logic [31:0] mem32 [256];
  int          waitCfg16, waitCfg32, wc16, wc32;
  int          cyc, lastRet, relCyc;
  int          errCount, checkCount;
  logic        prevWait16, prevWe16;
  logic [15:0] prevAddr16, prevWdata16;

  typedef struct {
    string       tag;
    int          lat;
    logic [15:0] npc;
  } retT;
  retT sb[$];

  multicycle_core dut16 (
    .clock(clock), .reset(reset16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(ready16), .pc(pc16),
    .halted(halted16), .instr_count(cnt16), .dbg_sel(dbgSel16), .dbg_data(dbg16)
  );

  multicycle_core #(.DATA_W(32)) dut32 (
    .clock(clock), .reset(reset32), .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
    .mem_wdata(wdata32), .mem_rdata(rdata32), .mem_ready(ready32), .pc(pc32),
    .halted(halted32), .instr_count(cnt32), .dbg_sel(dbgSel32), .dbg_data(dbg32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] encI(input logic [3:0] op, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [5:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [15:0] encR(input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [2:0] rd, input logic [2:0] fn);
    return {4'h0, rs, rt, rd, fn};
  endfunction

  function automatic logic [15:0] encJ(input logic [11:0] a);
    return {4'h5, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expectRet(input string tag, input int lat, input logic [15:0] npc);
    retT e;
    e.tag = tag;
    e.lat = lat;
    e.npc = npc;
    sb.push_back(e);
  endtask

  task automatic memResp();
    ready16 = req16 && (wc16 >= waitCfg16);
    rdata16 = mem16[addr16];
    ready32 = req32 && (wc32 >= waitCfg32);
    rdata32 = mem32[addr32[7:0]];
  endtask

  task automatic step();
    if (req16 && ready16 && we16) mem16[addr16] = wdata16;
    if (req32 && ready32 && we32) mem32[addr32[7:0]] = wdata32;
    wc16        = (req16 && !ready16) ? wc16 + 1 : 0;
    wc32        = (req32 && !ready32) ? wc32 + 1 : 0;
    prevWait16  = req16 && !ready16;
    prevAddr16  = addr16;
    prevWe16    = we16;
    prevWdata16 = wdata16;
    @(posedge clock);
    #1;
    cyc++;
    memResp();
    if (prevWait16 && req16) begin
      check("holdAddr", addr16, prevAddr16);
      check("holdWe", we16, prevWe16);
      check("holdWdata", wdata16, prevWdata16);
    end
  endtask

  task automatic doReset16();
    reset16 = 1'b1;
    #1;
    memResp();
    check("rstReq", req16, 1'b0);
    check("rstWe", we16, 1'b0);
    check("rstAddr", addr16, 16'h0);
    check("rstWdata", wdata16, 16'h0);
    step();
    check("rstPc", pc16, 16'h0);
    check("rstCount", cnt16, 32'h0);
    check("rstHalted", halted16, 1'b0);
    dbgSel16 = 3'd1;
    #1;
    check("rstReg1", dbg16, 16'h0);
    reset16 = 1'b0;
    #1;
    memResp();
    check("firstReq", req16, 1'b1);
    check("firstAddr", addr16, 16'h0);
    check("firstWe", we16, 1'b0);
    relCyc  = cyc;
    lastRet = cyc;
  endtask

  task automatic runRetire(input int n, input int budget);
    int          got;
    int          t;
    logic [31:0] prev;
    retT         e;
    got  = 0;
    t    = 0;
    prev = cnt16;
    while (got < n && t < budget) begin
      step();
      t++;
      if (cnt16 != prev) begin
        check("countStep", cnt16, prev + 32'd1);
        if (sb.size() == 0) begin
          check("sbEmpty", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "Lat"}, cyc - lastRet, e.lat);
          check({e.tag, "Pc"}, pc16, e.npc);
        end
        lastRet = cyc;
        prev    = cnt16;
        got++;
      end
    end
    if (got < n) check("retireTimeout", got, n);
  endtask

  task automatic peek16(input string tag, input logic [2:0] r, input logic [15:0] exp);
    dbgSel16 = r;
    #1;
    check(tag, dbg16, exp);
  endtask

  initial begin
    errCount = 0; checkCount = 0; cyc = 0; lastRet = 0; relCyc = 0;
    waitCfg16 = 0; waitCfg32 = 0; wc16 = 0; wc32 = 0;
    ready16 = 1'b0; ready32 = 1'b0; rdata16 = '0; rdata32 = '0;
    prevWait16 = 1'b0; prevWe16 = 1'b0; prevAddr16 = '0; prevWdata16 = '0;
    dbgSel16 = 3'd0; dbgSel32 = 3'd0;
    reset16 = 1'b1; reset32 = 1'b1;
    for (int i = 0; i < 65536; i++) mem16[i] = 16'hF000;
    for (int i = 0; i < 256; i++) mem32[i] = 32'h0000F000;

    // Straight-line program, arithmetic, memory, branches and jump
    mem16[0]      = encI(4'd4, 3'd0, 3'd1, 6'd5);
    mem16[1]      = encI(4'd4, 3'd0, 3'd2, 6'h3D);
    mem16[2]      = encR(3'd1, 3'd2, 3'd3, 3'd0);
    mem16[3]      = encI(4'd2, 3'd0, 3'd1, 6'd2);
    mem16[4]      = encI(4'd1, 3'd0, 3'd4, 6'd2);
    mem16[5]      = encI(4'd4, 3'd0, 3'd0, 6'd7);
    mem16[6]      = encI(4'd3, 3'd1, 3'd2, 6'd1);
    mem16[7]      = encJ(12'h123);
    mem16[16'h123] = encR(3'd1, 3'd2, 3'd5, 3'd1);
    mem16[16'h124] = encR(3'd2, 3'd1, 3'd6, 3'd4);
    mem16[16'h125] = encR(3'd1, 3'd2, 3'd7, 3'd2);
    mem16[16'h126] = encR(3'd1, 3'd2, 3'd4, 3'd3);
    mem16[16'h127] = encR(3'd1, 3'd2, 3'd3, 3'd4);
    mem16[16'h128] = encI(4'd3, 3'd1, 3'd1, 6'h3F);

    doReset16();
    step();
    check("decodePc", pc16, 16'h1);
    expectRet("addi1", 4, 16'h1);
    expectRet("addi2", 4, 16'h2);
    expectRet("add", 4, 16'h3);
    runRetire(3, 40);
    check("count12Cycles", cyc - relCyc, 12);
    check("countAfterAdd", cnt16, 32'd3);
    peek16("r3Add", 3'd3, 16'h0002);

    waitCfg16 = 3;
    memResp();
    expectRet("sw", 10, 16'h4);
    expectRet("lw", 11, 16'h5);
    runRetire(2, 60);
    check("mem2", mem16[2], 16'h0005);
    peek16("r4Lw", 3'd4, 16'h0005);

    waitCfg16 = 0;
    memResp();
    expectRet("addiR0", 4, 16'h6);
    expectRet("beqFall", 3, 16'h7);
    expectRet("jump", 2, 16'h123);
    expectRet("sub", 4, 16'h124);
    expectRet("sltTrue", 4, 16'h125);
    expectRet("and", 4, 16'h126);
    expectRet("or", 4, 16'h127);
    expectRet("sltFalse", 4, 16'h128);
    expectRet("beqLoop1", 3, 16'h128);
    expectRet("beqLoop2", 3, 16'h128);
    runRetire(10, 80);
    peek16("r0Zero", 3'd0, 16'h0000);
    peek16("r5Sub", 3'd5, 16'h0008);
    peek16("r6Slt", 3'd6, 16'h0001);
    peek16("r7And", 3'd7, 16'h0005);
    peek16("r4Or", 3'd4, 16'hFFFD);
    peek16("r3Slt", 3'd3, 16'h0000);

    // Illegal opcode at pc 7 halts; stray ready while idle must be ignored
    mem16[0] = encJ(12'h007);
    mem16[7] = 16'hF000;
    doReset16();
    expectRet("jHalt", 2, 16'h7);
    runRetire(1, 20);
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      check("haltFlag", halted16, 1'b1);
      check("haltReq", req16, 1'b0);
      ready16 = 1'b1;
      step();
    end
    check("haltCount", cnt16, 32'd1);

    mem16[0] = encR(3'd1, 3'd1, 3'd1, 3'd5);
    doReset16();
    step();
    step();
    step();
    check("illegalFunctHalt", halted16, 1'b1);
    check("illegalFunctCount", cnt16, 32'd0);
    check("illegalFunctReq", req16, 1'b0);

    // 32-bit core: wide wrap arithmetic, then reset during a stalled store
    mem32[0] = {16'h0, encI(4'd4, 3'd0, 3'd1, 6'h3F)};
    mem32[1] = {16'h0, encR(3'd1, 3'd1, 3'd1, 3'd0)};
    mem32[2] = {16'h0, encI(4'd2, 3'd0, 3'd1, 6'd3)};
    mem32[3] = 32'h0000DEAD;
    dbgSel32 = 3'd1;
    #1;
    memResp();
    check("rst32Req", req32, 1'b0);
    step();
    reset32 = 1'b0;
    #1;
    memResp();
    repeat (4) step();
    check("w32AddiNeg1", dbg32, 32'hFFFFFFFF);
    check("w32Count1", cnt32, 32'd1);
    repeat (4) step();
    check("w32AddWrap", dbg32, 32'hFFFFFFFE);
    waitCfg32 = 5;
    memResp();
    begin
      int t;
      t = 0;
      while (!we32 && t < 40) begin
        step();
        t++;
      end
    end
    check("w32MemReached", we32, 1'b1);
    check("w32SwAddr", addr32, 16'h0003);
    check("w32SwData", wdata32, 32'hFFFFFFFE);
    step();
    step();
    reset32 = 1'b1;
    #1;
    memResp();
    check("abortReq", req32, 1'b0);
    check("abortWe", we32, 1'b0);
    mem32[0] = {16'h0, encJ(12'h000)};
    step();
    reset32 = 1'b0;
    waitCfg32 = 0;
    #1;
    memResp();
    check("abortRefetchAddr", addr32, 16'h0000);
    check("abortRefetchWe", we32, 1'b0);
    repeat (10) step();
    check("abortNoStore", mem32[3], 32'h0000DEAD);
    check("abortLoopCount", cnt32, 32'd5);
    check("abortLoopPc", pc32, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
